// File: rtl/multicycle_seq_pkg.sv
// Shared opcode, state and timeout definitions for the multicycle control sequencer.
// The opcode constants are shared with the instruction decoder.
package multicycle_seq_pkg;

    localparam logic [4:0] R_TYPE     = 5'b01100;
    localparam logic [4:0] I_CAL      = 5'b00100;
    localparam logic [4:0] I_LOAD     = 5'b00000;
    localparam logic [4:0] S_TYPE     = 5'b01000;
    localparam logic [4:0] B_TYPE     = 5'b11000;
    localparam logic [4:0] LUI_TYPE   = 5'b01101;
    localparam logic [4:0] AUIPC_TYPE = 5'b00101;
    localparam logic [4:0] JAL_TYPE   = 5'b11011;
    localparam logic [4:0] JALR_TYPE  = 5'b11001;

    localparam int              WAIT_W  = 4;
    localparam logic [WAIT_W-1:0] TIMEOUT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            R_TYPE, I_CAL, I_LOAD, S_TYPE, B_TYPE,
            LUI_TYPE, AUIPC_TYPE, JAL_TYPE, JALR_TYPE: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_seq_mem_wait_timer.sv
// Memory wait counter: counts stalled FETCH/MEM cycles and flags the timeout
// combinationally on the cycle the count would reach the limit.
module mem_wait_timer
    import multicycle_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wait_en,
    input  logic mem_ready,
    input  logic clr,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt;
    logic              stall;

    assign stall = wait_en & ~mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (stall) cnt <= cnt + 1'b1;
    end

    // Fires while the stalled cycle that brings the count to the limit is in progress,
    // so a same-cycle mem_ready still wins.
    assign timeout = stall & (cnt == TIMEOUT - 1'b1);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared memory
// port, a stall timeout and a sticky TRAP state that only reset leaves.
module multicycle_seq
    import multicycle_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_en,
    output logic       pc_en,
    output logic       wb_en,
    output logic       retire,
    output logic       err,
    output logic [2:0] state
);

    state_t cur, nxt;
    logic   timeout, wait_en, clr;
    logic   req_c, we_c, as_c, ir_c, pc_c, wb_c, ret_c, err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    assign wait_en = (cur == S_FETCH) | (cur == S_MEM);
    assign clr     = (nxt != cur);

    mem_wait_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wait_en   (wait_en),
        .mem_ready (mem_ready),
        .clr       (clr),
        .timeout   (timeout)
    );

    always_comb begin
        nxt   = cur;
        req_c = 1'b0;
        we_c  = 1'b0;
        as_c  = 1'b0;
        ir_c  = 1'b0;
        pc_c  = 1'b0;
        wb_c  = 1'b0;
        ret_c = 1'b0;
        err_c = 1'b0;
        case (cur)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_c = 1'b1;
                    nxt  = S_DECODE;
                end else if (timeout) begin
                    nxt = S_TRAP;
                end
            end
            S_DECODE: nxt = is_legal_op(op) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (op == I_LOAD || op == S_TYPE) begin
                    nxt = S_MEM;
                end else if (op == B_TYPE) begin
                    pc_c  = 1'b1;
                    ret_c = 1'b1;
                    nxt   = S_FETCH;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                req_c = 1'b1;
                as_c  = 1'b1;
                we_c  = (op == S_TYPE);
                if (mem_ready) begin
                    if (op == S_TYPE) begin
                        pc_c  = 1'b1;
                        ret_c = 1'b1;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout) begin
                    nxt = S_TRAP;
                end
            end
            S_WB: begin
                wb_c  = 1'b1;
                pc_c  = 1'b1;
                ret_c = 1'b1;
                nxt   = S_FETCH;
            end
            S_TRAP:  err_c = 1'b1;
            default: nxt = S_TRAP;
        endcase
    end

    // Strobes are forced low combinationally while reset is held.
    assign mem_req  = rst_n & req_c;
    assign mem_we   = rst_n & we_c;
    assign addr_sel = rst_n & as_c;
    assign ir_en    = rst_n & ir_c;
    assign pc_en    = rst_n & pc_c;
    assign wb_en    = rst_n & wb_c;
    assign retire   = rst_n & ret_c;
    assign err      = rst_n & err_c;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// trace from the op and the memory latencies, then replayed against the DUT.
module tb_multicycle_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] op = 5'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_en, pc_en, wb_en, retire, err;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    logic [10:0] exp_q[$];
    bit          rdy_q[$];
    logic [10:0] obs;

    multicycle_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .wb_en     (wb_en),
        .retire    (retire),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, addr_sel, ir_en, pc_en, wb_en, retire, err};

    function automatic logic [10:0] ent(input int st, input bit req, input bit we, input bit as,
                                        input bit ir, input bit pc, input bit wb, input bit ret,
                                        input bit er);
        logic [2:0] s;
        s = 3'(st);
        return {s, req, we, as, ir, pc, wb, ret, er};
    endfunction

    function automatic bit legal(input logic [4:0] o);
        logic [4:0] ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b01101,
                                5'b00101, 5'b11011, 5'b11001, 5'b11000};
        foreach (ops[i]) if (ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [10:0] e);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, e);
        end
    endtask

    task automatic push(input logic [10:0] e, input bit r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    task automatic push_trap(input int hold);
        for (int i = 0; i < hold; i++) push(ent(7, 0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
    endtask

    // Expected trace from the instruction-level rules; fw/mw are stall cycles before ready.
    task automatic build(input logic [4:0] o, input int fw, input int mw, input int hold);
        bit st;
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i < fw && i < 15; i++) push(ent(0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        if (fw >= 15) begin push_trap(hold); return; end
        push(ent(0, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1);
        push(ent(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        if (!legal(o)) begin push_trap(hold); return; end
        if (o == 5'b11000) begin
            push(ent(2, 0, 0, 0, 0, 1, 0, 1, 0), 1'($urandom));
            return;
        end
        push(ent(2, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        if (o == 5'b00000 || o == 5'b01000) begin
            st = (o == 5'b01000);
            for (int i = 0; i < mw && i < 15; i++) push(ent(3, 1, st, 1, 0, 0, 0, 0, 0), 1'b0);
            if (mw >= 15) begin push_trap(hold); return; end
            if (st) begin
                push(ent(3, 1, 1, 1, 0, 1, 0, 1, 0), 1'b1);
                return;
            end
            push(ent(3, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1);
        end
        push(ent(4, 0, 0, 0, 0, 1, 1, 1, 0), 1'($urandom));
    endtask

    // Entered at a clock low phase; asserts reset between edges and releases one cycle later.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check({tag, "_rst_async"}, 11'b0);
        mem_ready = 1'($urandom);
        @(negedge clk);
        #1 check({tag, "_rst_held"}, 11'b0);
        rst_n = 1'b1;
    endtask

    task automatic run(input string tag, input logic [4:0] o, input int fw, input int mw,
                       input int hold, input int abort_at);
        logic [10:0] last;
        op = o;
        build(o, fw, mw, hold);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
                do_reset(tag);
                return;
            end
            mem_ready = rdy_q[k];
            #1 check(tag, exp_q[k]);
            @(negedge clk);
        end
        last = exp_q[exp_q.size() - 1];
        if (last[10:8] == 3'd7) do_reset(tag);
    endtask

    initial begin
        logic [4:0] o;
        int fw, mw;
        repeat (2) @(negedge clk);
        #1 check("reset_state", 11'b0);
        rst_n = 1'b1;

        run("add",        5'b01100, 0, 0, 3, -1);
        run("add2",       5'b01100, 0, 0, 3, -1);
        run("load",       5'b00000, 0, 3, 3, -1);
        run("store",      5'b01000, 1, 2, 3, -1);
        run("branch",     5'b11000, 2, 0, 3, -1);
        run("illegal",    5'b11111, 0, 0, 20, -1);
        run("fetch_to",   5'b01100, 15, 0, 3, -1);
        run("fetch_edge", 5'b01100, 14, 0, 3, -1);
        run("mem_to",     5'b00000, 0, 15, 3, -1);
        run("mem_edge",   5'b01000, 0, 14, 3, -1);
        run("mem_rst",    5'b00000, 0, 10, 3, 6);
        run("restart",    5'b00100, 0, 0, 3, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) o = 5'($urandom);
            else begin
                case ($urandom_range(0, 8))
                    0: o = 5'b01100; 1: o = 5'b00100; 2: o = 5'b00000;
                    3: o = 5'b01000; 4: o = 5'b01101; 5: o = 5'b00101;
                    6: o = 5'b11011; 7: o = 5'b11001; default: o = 5'b11000;
                endcase
            end
            fw = ($urandom_range(0, 11) == 0) ? 15 : int'($urandom_range(0, 4));
            mw = ($urandom_range(0, 11) == 0) ? 15 : int'($urandom_range(0, 4));
            run("random", o, fw, mw, 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
